scaler_refresh_gen: RTL and testbench

Upstream timing stage for the scaler bank. Generates the single-cycle refresh strobe that every scaler instance uses to latch its count and clear its counter. The strobe comes from one of three sources: a programmable free-running period, an external PPS edge (with a timeout fallback), or a software manual request using a four-phase handshake. It also publishes a refresh sequence number so readout can detect missed or duplicate scaler frames.

---
 rtl/scaler_refresh_pkg.sv | 13 +
 rtl/pps_sync_edge.sv | 27 ++
 rtl/scaler_refresh_gen.sv | 151 +++++++++++++++
 tb/tb_scaler_refresh_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_refresh_pkg.sv
// Shared types and constants for the scaler refresh generator.
package scaler_refresh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FREE = 2'd1,
    PPS  = 2'd2
  } refresh_state_e;

  localparam int MIN_PERIOD      = 2;
  localparam int PPS_SYNC_STAGES = 2;

endpackage

// File: rtl/pps_sync_edge.sv
// Brings the asynchronous PPS input into clk_i and emits a one-cycle pulse
// on each synchronized rising edge.
module pps_sync_edge
  import scaler_refresh_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic pps_i,
  output logic pps_edge_o
);

  logic [PPS_SYNC_STAGES-1:0] sync_q;
  logic                       pps_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      pps_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[PPS_SYNC_STAGES-2:0], pps_i};
      pps_prev_q <= sync_q[PPS_SYNC_STAGES-1];
    end
  end

  assign pps_edge_o = sync_q[PPS_SYNC_STAGES-1] & ~pps_prev_q;

endmodule

// File: rtl/scaler_refresh_gen.sv
// Refresh strobe generator for the scaler bank: free-running, PPS-locked or manual.
// Optional SCALER_REFRESH_TSTAMP_EN adds a cycle timestamp latched on each strobe.
//
// state | meaning
// IDLE  | disabled, only manual requests fire
// FREE  | strobe every period_q cycles
// PPS   | strobe on PPS edge, timeout after period_q cycles sets pps_lost
module scaler_refresh_gen
  import scaler_refresh_pkg::*;
#(
  parameter int                      PERIOD_WIDTH   = 32,
  parameter int                      CNT_WIDTH      = 16,
  parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = PERIOD_WIDTH'(7_500_000)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    pps_sel_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    pps_i,
  input  logic                    manual_req_i,
  output logic                    manual_ack_o,
  output logic                    refresh_o,
  output logic [CNT_WIDTH-1:0]    refresh_cnt_o,
  output logic                    pps_lost_o,
  output logic [1:0]              state_o
`ifdef SCALER_REFRESH_TSTAMP_EN
  ,
  output logic [31:0]             tstamp_o
`endif
);

  refresh_state_e          state_q, state_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_clamped;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    refresh_q;
  logic                    ack_q;
  logic                    armed_q;
  logic                    lost_q;
  logic                    pps_edge;
  logic                    switching;
  logic                    timer_hit;
  logic                    timer_fire;
  logic                    manual_fire;
  logic                    lost_set;
  logic                    fire;

  pps_sync_edge u_pps_sync_edge (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pps_i      (pps_i),
    .pps_edge_o (pps_edge)
  );

  assign period_clamped = (period_i < PERIOD_WIDTH'(MIN_PERIOD)) ?
                          PERIOD_WIDTH'(MIN_PERIOD) : period_i;

  always_comb begin
    state_d     = IDLE;
    timer_fire  = 1'b0;
    lost_set    = 1'b0;
    if (enable_i) begin
      state_d = pps_sel_i ? PPS : FREE;
    end
    switching   = (state_d != state_q);
    timer_hit   = (timer_q == (period_q - PERIOD_WIDTH'(1)));
    // armed_q blocks a request that was already high when reset released
    manual_fire = manual_req_i & ~ack_q & armed_q;
    if (!switching) begin
      case (state_q)
        FREE: timer_fire = timer_hit;
        PPS: begin
          timer_fire = timer_hit | pps_edge;
          lost_set   = timer_hit & ~pps_edge;
        end
        default: timer_fire = 1'b0;
      endcase
    end
    fire = manual_fire | timer_fire;
    if (switching || fire || (state_q == IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      period_q  <= DEFAULT_PERIOD;
      cnt_q     <= '0;
      refresh_q <= 1'b0;
      ack_q     <= 1'b0;
      armed_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      refresh_q <= fire;
      if ((switching && (state_d != IDLE)) || fire) begin
        period_q <= period_clamped;
      end
      if (fire) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (manual_fire) begin
        ack_q <= 1'b1;
      end else if (!manual_req_i) begin
        ack_q <= 1'b0;
      end
      if (manual_fire) begin
        armed_q <= 1'b0;
      end else if (!manual_req_i) begin
        armed_q <= 1'b1;
      end
      if (switching && (state_d == IDLE)) begin
        lost_q <= 1'b0;
      end else if (lost_set) begin
        lost_q <= 1'b1;
      end
    end
  end

`ifdef SCALER_REFRESH_TSTAMP_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] tstamp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      tstamp_q    <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (fire) begin
        tstamp_q <= cycle_cnt_q;
      end
    end
  end

  assign tstamp_o = tstamp_q;
`endif

  assign refresh_o     = refresh_q;
  assign refresh_cnt_o = cnt_q;
  assign manual_ack_o  = ack_q;
  assign pps_lost_o    = lost_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_scaler_refresh_gen.sv
// Self-checking bench for scaler_refresh_gen; the sequence counter is narrowed
// to 8 bits so the wrap scenario runs in a few hundred cycles.
module tb_scaler_refresh_gen;

  localparam int PW = 32;
  localparam int CW = 8;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          pps_sel_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic          pps_i = 1'b0;
  logic          manual_req_i = 1'b0;
  logic          manual_ack_o;
  logic          refresh_o;
  logic [CW-1:0] refresh_cnt_o;
  logic          pps_lost_o;
  logic [1:0]    state_o;
`ifdef SCALER_REFRESH_TSTAMP_EN
  logic [31:0]   tstamp_o;
`endif

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  exp_t          e;
  logic [CW-1:0] exp_cnt = '0;

  scaler_refresh_gen #(
    .PERIOD_WIDTH (PW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .pps_sel_i     (pps_sel_i),
    .period_i      (period_i),
    .pps_i         (pps_i),
    .manual_req_i  (manual_req_i),
    .manual_ack_o  (manual_ack_o),
    .refresh_o     (refresh_o),
    .refresh_cnt_o (refresh_cnt_o),
    .pps_lost_o    (pps_lost_o),
    .state_o       (state_o)
`ifdef SCALER_REFRESH_TSTAMP_EN
    ,
    .tstamp_o      (tstamp_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic push_exp(input int at_cyc);
    exp_cnt = exp_cnt + 1'b1;
    e.cyc = at_cyc;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (refresh_o !== 1'b0 || refresh_cnt_o !== '0 || manual_ack_o !== 1'b0 ||
        pps_lost_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ref=%b cnt=%0d ack=%b lost=%b st=%0d, want all 0",
               refresh_o, refresh_cnt_o, manual_ack_o, pps_lost_o, state_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checks++;
      if (refresh_o !== 1'b0 || state_o !== 2'd0) begin
        errors++;
        $display("FAIL idle_quiet: got ref=%b st=%0d, want ref=0 st=0", refresh_o, state_o);
      end
    end
  endtask

  task automatic test_free();
    int t0;
    @(negedge clk_i);
    period_i = 10; pps_sel_i = 1'b0; enable_i = 1'b1; t0 = cyc;
    for (int i = 0; i < 10; i++) push_exp(t0 + 11 + 10 * i);
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        checks++;
        if (state_o !== 2'd1) begin
          errors++; $display("FAIL free_state: got %0d, want 1", state_o);
        end
      end
      if (k == 101) enable_i = 1'b0;
      if (refresh_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL free_strobe: unexpected strobe at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || refresh_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL free_strobe: got cycle %0d cnt %0d, want cycle %0d cnt %0d",
                     cyc, refresh_cnt_o, e.cyc, e.cnt);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || refresh_cnt_o !== 8'd10) begin
      errors++;
      $display("FAIL free_total: got cnt %0d with %0d strobes missing, want cnt 10 and 0 missing",
               refresh_cnt_o, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pps_locked();
    @(negedge clk_i);
    period_i = 1000; pps_sel_i = 1'b1; enable_i = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk_i);
      if (refresh_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL pps_strobe: unexpected strobe at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || refresh_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL pps_strobe: got cycle %0d cnt %0d, want cycle %0d cnt %0d",
                     cyc, refresh_cnt_o, e.cyc, e.cnt);
          end
        end
      end
      if (k % 200 == 50) begin
        pps_i = 1'b1;
        push_exp(cyc + 3);
      end
      if (k % 200 == 70) pps_i = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0 || pps_lost_o !== 1'b0 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL pps_final: got missing=%0d lost=%b st=%0d, want 0 0 2",
               exp_q.size(), pps_lost_o, state_o);
      exp_q.delete();
    end
  endtask

  task automatic test_pps_timeout();
    int t0;
    @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    period_i = 50; enable_i = 1'b1; t0 = cyc;
    for (int i = 1; i <= 3; i++) push_exp(t0 + 1 + 50 * i);
    for (int k = 1; k <= 151; k++) begin
      @(negedge clk_i);
      if (k == 50) begin
        checks++;
        if (pps_lost_o !== 1'b0) begin
          errors++; $display("FAIL lost_early: got %b, want 0", pps_lost_o);
        end
      end
      if (k == 51) begin
        checks++;
        if (pps_lost_o !== 1'b1) begin
          errors++; $display("FAIL lost_set: got %b, want 1", pps_lost_o);
        end
      end
      if (refresh_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL timeout_strobe: unexpected strobe at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || refresh_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL timeout_strobe: got cycle %0d cnt %0d, want cycle %0d cnt %0d",
                     cyc, refresh_cnt_o, e.cyc, e.cnt);
          end
        end
      end
    end
    enable_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0 || pps_lost_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL lost_clear: got missing=%0d lost=%b st=%0d, want 0 0 0",
               exp_q.size(), pps_lost_o, state_o);
      exp_q.delete();
    end
  endtask

  task automatic test_manual_coincide();
    int t0;
    @(negedge clk_i);
    period_i = 10; pps_sel_i = 1'b0; enable_i = 1'b1; t0 = cyc;
    push_exp(t0 + 11);
    push_exp(t0 + 21);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk_i);
      if (refresh_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL manual_strobe: unexpected strobe at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || refresh_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL manual_strobe: got cycle %0d cnt %0d, want cycle %0d cnt %0d",
                     cyc, refresh_cnt_o, e.cyc, e.cnt);
          end
        end
      end
      if (cyc == t0 + 10) manual_req_i = 1'b1;
      if (cyc == t0 + 11 || cyc == t0 + 14) begin
        checks++;
        if (manual_ack_o !== 1'b1) begin
          errors++; $display("FAIL manual_ack_high: got %b at cycle %0d, want 1", manual_ack_o, cyc);
        end
      end
      if (cyc == t0 + 14) manual_req_i = 1'b0;
      if (cyc == t0 + 15) begin
        checks++;
        if (manual_ack_o !== 1'b0) begin
          errors++; $display("FAIL manual_ack_drop: got %b, want 0", manual_ack_o);
        end
      end
    end
    enable_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL manual_missing: got %0d strobes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_min_period_wrap();
    int t0;
    int n;
    bit saw_wrap;
    saw_wrap = 1'b0;
    @(negedge clk_i);
    period_i = 0; pps_sel_i = 1'b0; enable_i = 1'b1; t0 = cyc;
    n = 256 - int'(exp_cnt) + 2;
    for (int i = 0; i < n; i++) push_exp(t0 + 3 + 2 * i);
    for (int k = 1; k <= 2 * n + 1; k++) begin
      @(negedge clk_i);
      if (refresh_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_strobe: unexpected strobe at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cnt == '0) saw_wrap = 1'b1;
          if (e.cyc != cyc || refresh_cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL wrap_strobe: got cycle %0d cnt %0d, want cycle %0d cnt %0d",
                     cyc, refresh_cnt_o, e.cyc, e.cnt);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || !saw_wrap) begin
      errors++;
      $display("FAIL wrap_done: got missing=%0d wrapped=%b, want 0 1", exp_q.size(), saw_wrap);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_interval();
    @(negedge clk_i);
    manual_req_i = 1'b1;
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (refresh_o !== 1'b0 || refresh_cnt_o !== '0 || manual_ack_o !== 1'b0 ||
        pps_lost_o !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got ref=%b cnt=%0d ack=%b lost=%b st=%0d, want all 0",
               refresh_o, refresh_cnt_o, manual_ack_o, pps_lost_o, state_o);
    end
    exp_q.delete();
    exp_cnt = '0;
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      checks++;
      if (refresh_o !== 1'b0 || manual_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL stale_req: got ref=%b ack=%b, want 0 0", refresh_o, manual_ack_o);
      end
    end
    manual_req_i = 1'b0;
    @(negedge clk_i);
    manual_req_i = 1'b1;
    push_exp(cyc + 1);
    @(negedge clk_i);
    checks++;
    if (refresh_o !== 1'b1 || exp_q.size() == 0) begin
      errors++; $display("FAIL rearm_strobe: got ref=%b, want 1", refresh_o);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || refresh_cnt_o !== e.cnt || manual_ack_o !== 1'b1) begin
        errors++;
        $display("FAIL rearm_strobe: got cycle %0d cnt %0d ack %b, want cycle %0d cnt %0d ack 1",
                 cyc, refresh_cnt_o, manual_ack_o, e.cyc, e.cnt);
      end
    end
    manual_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (manual_ack_o !== 1'b0 || refresh_o !== 1'b0) begin
      errors++;
      $display("FAIL rearm_release: got ack=%b ref=%b, want 0 0", manual_ack_o, refresh_o);
    end
  endtask

  initial begin
    test_reset();
    test_free();
    test_pps_locked();
    test_pps_timeout();
    test_manual_coincide();
    test_min_period_wrap();
    test_reset_mid_interval();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
